jk_sync_tx: RTL and testbench

Transmitter end of the J/K line protocol consumed by the sync-detect receiver (`in_k`/`in_j`/`in_en` side).
- On request, serialises one frame onto k/j/en lines: SYNC field, NRZI-encoded payload with bit stuffing, EOP.
- Used as functional stimulus source and as loopback driver for the receiver during BIST.

---
 rtl/jk_sync_tx.sv | 183 ++++++++++++++++++
 tb/tb_jk_sync_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/jk_sync_tx.sv
// J/K line transmitter: one frame per request, made of the SYNC field, an
// NRZI payload sent LSB first with bit stuffing, then EOP (SE0, SE0, J).
module jk_sync_tx #(
  parameter int DATA_W    = 8,
  parameter int SYNC_LEN  = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              out_k,
  output logic              out_j,
  output logic              out_en,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W  = $clog2(SYNC_LEN + 3);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int ONES_W = $clog2(STUFF_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                level_q, level_d;
  logic                k_q, k_d;
  logic                j_q, j_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sync_last;
  logic [CNT_W-1:0]    sync_next;
  logic                sync_next_k;
  logic                src_level;
  logic [ONES_W-1:0]   src_ones;
  logic [BIT_W-1:0]    src_bit;
  logic                stuff;
  logic                toggle;
  logic                emit_data;

  assign out_k   = k_q;
  assign out_j   = j_q;
  assign out_en  = en_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    ones_d    = ones_q;
    level_d   = level_q;
    k_d       = k_q;
    j_d       = j_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    emit_data = 1'b0;

    sync_last   = (cnt_q == CNT_W'(SYNC_LEN - 1));
    sync_next   = cnt_q + CNT_W'(1);
    sync_next_k = (sync_next == CNT_W'(SYNC_LEN - 1)) || !sync_next[0];

    // The first payload symbol is chosen on the edge leaving SYNC, so the
    // NRZI context is taken as a fresh K-level, zero-run start there.
    src_level = (state_q == S_SYNC) ? 1'b1 : level_q;
    src_ones  = (state_q == S_SYNC) ? '0 : ones_q;
    src_bit   = (state_q == S_SYNC) ? '0 : bit_q;
    stuff     = (src_ones == ONES_W'(STUFF_RUN));
    toggle    = stuff || !data_q[0];

    case (state_q)
      S_IDLE: begin
        k_d  = 1'b0;
        j_d  = 1'b1;
        en_d = 1'b0;
        if (tx_start) begin
          data_d  = tx_data;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SYNC;
          k_d     = 1'b1;
          j_d     = 1'b0;
          en_d    = 1'b1;
        end
      end
      S_SYNC: begin
        if (sync_last) begin
          state_d   = S_DATA;
          emit_data = 1'b1;
        end else begin
          cnt_d = sync_next;
          k_d   = sync_next_k;
          j_d   = !sync_next_k;
          en_d  = 1'b1;
        end
      end
      S_DATA: begin
        // A pending stuff is still owed after the last payload bit.
        if (!stuff && (bit_q == BIT_W'(DATA_W))) begin
          state_d = S_EOP;
          cnt_d   = '0;
          k_d     = 1'b0;
          j_d     = 1'b0;
          en_d    = 1'b1;
        end else begin
          emit_data = 1'b1;
        end
      end
      S_EOP: begin
        if (cnt_q == CNT_W'(0)) begin
          cnt_d = CNT_W'(1);
          k_d   = 1'b0;
          j_d   = 1'b0;
          en_d  = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d = CNT_W'(2);
          k_d   = 1'b0;
          j_d   = 1'b1;
          en_d  = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
          k_d     = 1'b0;
          j_d     = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_data) begin
      level_d = toggle ? !src_level : src_level;
      ones_d  = toggle ? '0 : src_ones + ONES_W'(1);
      bit_d   = src_bit;
      k_d     = level_d;
      j_d     = !level_d;
      en_d    = 1'b1;
      if (!stuff) begin
        data_d = data_q >> 1;
        bit_d  = src_bit + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      ones_q  <= '0;
      level_q <= 1'b1;
      k_q     <= 1'b0;
      j_q     <= 1'b1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      k_q     <= k_d;
      j_q     <= j_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_jk_sync_tx.sv
// Bench for jk_sync_tx: a behavioural NRZI/stuffing model fills a symbol
// queue per frame, and every driven line cycle is popped and compared.
module tb_jk_sync_tx;

  localparam logic [1:0] SYM_K   = 2'b10;
  localparam logic [1:0] SYM_J   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       out_k, out_j, out_en, tx_busy, tx_done;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         exp_len;
    int         pulse_at;
  } vec_t;

  vec_t vecs[5];

  jk_sync_tx #(.DATA_W(8), .SYNC_LEN(8), .STUFF_RUN(6)) dut (
    .CLK(CLK), .RST(RST), .tx_start(tx_start), .tx_data(tx_data),
    .out_k(out_k), .out_j(out_j), .out_en(out_en),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected line symbols for one frame, derived from the protocol rules.
  task automatic buildExpected(input logic [7:0] d);
    logic level;
    int   ones;
    for (int i = 0; i < 8; i++)
      exp_q.push_back((i == 7 || (i % 2) == 0) ? SYM_K : SYM_J);
    level = 1'b1;
    ones  = 0;
    for (int b = 0; b < 8; b++) begin
      if (ones == 6) begin
        level = !level;
        ones  = 0;
        exp_q.push_back(level ? SYM_K : SYM_J);
      end
      if (d[b]) ones++;
      else begin
        level = !level;
        ones  = 0;
      end
      exp_q.push_back(level ? SYM_K : SYM_J);
    end
    if (ones == 6) begin
      level = !level;
      exp_q.push_back(level ? SYM_K : SYM_J);
    end
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_J);
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge CLK);
    tx_data  = d;
    tx_start = 1'b1;
    buildExpected(d);
  endtask

  task automatic monitorFrame(input int exp_len, input bit hold, input int pulse_at);
    int en_cnt = 0;
    bit got_done = 1'b0;
    for (int c = 0; c < 80 && !got_done; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        checkOutput("first_symbol_en", int'(out_en), 1);
        checkOutput("busy_after_accept", int'(tx_busy), 1);
      end
      if (out_en) begin
        en_cnt++;
        if (exp_q.size() == 0) checkOutput("extra_symbol", 1, 0);
        else checkOutput("symbol", int'({out_k, out_j}), int'(exp_q.pop_front()));
      end
      if (tx_done) begin
        got_done = 1'b1;
        checkOutput("done_busy", int'(tx_busy), 0);
        checkOutput("done_en", int'(out_en), 0);
        checkOutput("done_line", int'({out_k, out_j}), int'(SYM_J));
      end
      if (!hold) tx_start = 1'b0;
      if (pulse_at >= 0 && en_cnt >= pulse_at && en_cnt < pulse_at + 2) begin
        tx_start = 1'b1;
        tx_data  = 8'h00;
      end
    end
    checkOutput("frame_done", int'(got_done), 1);
    checkOutput("en_count", en_cnt, exp_len);
    checkOutput("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    if (!hold) begin
      @(negedge CLK);
      checkOutput("done_pulse_width", int'(tx_done), 0);
      checkOutput("idle_en", int'(out_en), 0);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h00, exp_len: 19, pulse_at: -1};
    vecs[1] = '{data: 8'hFF, exp_len: 20, pulse_at: -1};
    vecs[2] = '{data: 8'h3F, exp_len: 20, pulse_at: -1};
    vecs[3] = '{data: 8'hA5, exp_len: 19, pulse_at: 12};
    vecs[4] = '{data: 8'h55, exp_len: 19, pulse_at: -1};

    #1 RST = 1'b1;
    #1 checkOutput("reset_state", int'({out_k, out_j, out_en, tx_busy, tx_done}), 5'b01000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("idle_state", int'({out_k, out_j, out_en, tx_busy, tx_done}), 5'b01000);
    end

    for (int v = 0; v < 5; v++) begin
      $display("[TB] frame data=%02h", vecs[v].data);
      applyStimulus(vecs[v].data);
      monitorFrame(vecs[v].exp_len, 1'b0, vecs[v].pulse_at);
    end

    // Back-to-back with tx_start held: second frame must start right after tx_done.
    applyStimulus(8'h00);
    monitorFrame(19, 1'b1, -1);
    tx_data = 8'h3F;
    buildExpected(8'h3F);
    monitorFrame(20, 1'b0, -1);

    // Reset in the middle of the payload, between clock edges.
    applyStimulus(8'h55);
    repeat (12) @(negedge CLK);
    tx_start = 1'b0;
    #2 RST = 1'b1;
    #1 checkOutput("midframe_reset", int'({out_k, out_j, out_en, tx_busy, tx_done}), 5'b01000);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("post_reset_idle", int'({out_k, out_j, out_en, tx_busy, tx_done}), 5'b01000);
    end
    applyStimulus(8'h55);
    monitorFrame(19, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
